// File: rtl/chan_scan_mux.sv
// Parametrised CH-channel, DW-bit registered selector with manual load and auto-scan modes.
// Optional even-parity output dout_par is enabled by defining CHAN_SCAN_PARITY_EN.
module chan_scan_mux #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CH    = 8,
  parameter int unsigned SELW  = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CH*DW-1:0]  din,
  input  logic              mode,
  input  logic [SELW-1:0]   sel_in,
  input  logic              sel_load,
  input  logic              hold,
  output logic [DW-1:0]     dout,
  output logic              dout_vld,
  output logic [SELW-1:0]   cur_sel,
  output logic              scan_done
`ifdef CHAN_SCAN_PARITY_EN
  ,
  output logic              dout_par
`endif
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [0:0] {StManual, StScan} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            new_q, new_d;
  logic            wrap_d;
  logic            last_ch;
  logic [DW-1:0]   dsel;
  logic [DW-1:0]   dout_q;
  logic            vld_q;
  logic            done_q;

  assign dsel    = din[DW*32'(sel_q) +: DW];
  assign last_ch = (sel_q == SELW'(CH - 1));

  always_comb begin
    state_d = mode ? StScan : StManual;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    new_d   = 1'b0;
    wrap_d  = 1'b0;
    if (!hold) begin
      if (state_q == StScan && mode) begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d  = '0;
          sel_d  = last_ch ? '0 : sel_q + 1'b1;
          new_d  = 1'b1;
          wrap_d = last_ch;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // Any mode entry/exit or manual residency keeps the dwell count at zero.
        cnt_d = '0;
        if (state_q == StManual && !mode && sel_load &&
            (32'(sel_in) < CH) && (sel_in != sel_q)) begin
          sel_d = sel_in;
          new_d = 1'b1;
        end
      end
    end
  end

  // new_q resets high so the first post-reset dout cycle is flagged valid.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StManual;
      sel_q   <= '0;
      cnt_q   <= '0;
      new_q   <= 1'b1;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      new_q   <= new_d;
      dout_q  <= dsel;
      vld_q   <= new_q;
      done_q  <= wrap_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = vld_q;
  assign cur_sel   = sel_q;
  assign scan_done = done_q;

`ifdef CHAN_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^dsel;
    end
  end

  assign dout_par = par_q;
`endif

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: an 8-channel DWELL=4 instance and a 6-channel DWELL=1 instance.
module tb_chan_scan_mux;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [8*DW-1:0] din_a;
  logic            mode_a, sel_load_a, hold_a;
  logic [2:0]      sel_in_a;
  logic [DW-1:0]   dout_a;
  logic            vld_a, done_a;
  logic [2:0]      cur_a;

  logic [6*DW-1:0] din_b;
  logic            mode_b, sel_load_b, hold_b;
  logic [2:0]      sel_in_b;
  logic [DW-1:0]   dout_b;
  logic            vld_b, done_b;
  logic [2:0]      cur_b;

`ifdef CHAN_SCAN_PARITY_EN
  logic par_a, par_b;
`endif

  chan_scan_mux #(.DW(8), .CH(8), .SELW(3), .DWELL(4)) u_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .din       (din_a),
    .mode      (mode_a),
    .sel_in    (sel_in_a),
    .sel_load  (sel_load_a),
    .hold      (hold_a),
    .dout      (dout_a),
    .dout_vld  (vld_a),
    .cur_sel   (cur_a),
    .scan_done (done_a)
`ifdef CHAN_SCAN_PARITY_EN
    ,
    .dout_par  (par_a)
`endif
  );

  chan_scan_mux #(.DW(8), .CH(6), .SELW(3), .DWELL(1)) u_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .din       (din_b),
    .mode      (mode_b),
    .sel_in    (sel_in_b),
    .sel_load  (sel_load_b),
    .hold      (hold_b),
    .dout      (dout_b),
    .dout_vld  (vld_b),
    .cur_sel   (cur_b),
    .scan_done (done_b)
`ifdef CHAN_SCAN_PARITY_EN
    ,
    .dout_par  (par_b)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       mode;
    logic       ld;
    logic [2:0] sel;
    logic       hold;
    logic [2:0] e_sel;
    logic [7:0] e_dout;
    logic       e_vld;
    logic       e_done;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int vcnt;
    int ecur;
    // Manual-mode vectors on instance A, applied right after reset release.
    vecs[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h10, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 8'h10, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 8'h15, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 8'h15, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 8'h15, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'd2, 1'b1, 3'd5, 8'h15, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 8'h15, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'd2, 1'b0, 3'd2, 8'h15, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd2, 8'h12, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd7, 8'h12, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 3'd7, 8'h17, 1'b1, 1'b0};

    for (int k = 0; k < 8; k++) din_a[k*DW +: DW] = 8'(8'h10 + k);
    for (int k = 0; k < 6; k++) din_b[k*DW +: DW] = 8'(8'h20 + k);
    mode_a = 1'b0; sel_load_a = 1'b0; hold_a = 1'b0; sel_in_a = 3'd0;
    mode_b = 1'b0; sel_load_b = 1'b0; hold_b = 1'b0; sel_in_b = 3'd0;

    #12;
    chk("rst_dout", 32'(dout_a), 32'h0);
    chk("rst_vld", 32'(vld_a), 32'h0);
    chk("rst_cur", 32'(cur_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
`ifdef CHAN_SCAN_PARITY_EN
    chk("rst_par", 32'(par_a), 32'h0);
`endif
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      mode_a = vecs[i].mode; sel_load_a = vecs[i].ld;
      sel_in_a = vecs[i].sel; hold_a = vecs[i].hold;
      tick();
      chk($sformatf("vec%0d_cur", i), 32'(cur_a), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d_dout", i), 32'(dout_a), 32'(vecs[i].e_dout));
      chk($sformatf("vec%0d_vld", i), 32'(vld_a), 32'(vecs[i].e_vld));
      chk($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].e_done));
    end

    // Return to channel 0, let the pending pulse drain, then enter scan.
    sel_in_a = 3'd0; sel_load_a = 1'b1; tick();
    sel_load_a = 1'b0; tick(); tick();
    chk("pre_scan_cur", 32'(cur_a), 32'h0);
    mode_a = 1'b1; tick();
    chk("scan_entry_cur", 32'(cur_a), 32'h0);
    vcnt = 0;
    for (int k = 1; k <= 46; k++) begin
      tick();
      chk($sformatf("scan%0d_cur", k), 32'(cur_a), 32'((k / 4) % 8));
      chk($sformatf("scan%0d_dout", k), 32'(dout_a), 32'(8'h10 + ((k - 1) / 4) % 8));
      chk($sformatf("scan%0d_done", k), 32'(done_a), 32'((k % 32) == 0));
      if (k <= 33 && vld_a === 1'b1) vcnt++;
    end
    chk("scan_vld_count", 32'(vcnt), 32'd8);

    // Channel 3, dwell count 2: freeze for 10 cycles while ch3 data changes.
    hold_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din_a[3*DW +: DW] = 8'(8'hA0 + i);
      tick();
      chk($sformatf("hold%0d_cur", i), 32'(cur_a), 32'd3);
      chk($sformatf("hold%0d_dout", i), 32'(dout_a), 32'(8'hA0 + i));
      chk($sformatf("hold%0d_vld", i), 32'(vld_a), 32'd0);
      chk($sformatf("hold%0d_done", i), 32'(done_a), 32'd0);
    end
    hold_a = 1'b0;
    din_a[3*DW +: DW] = 8'h13;
    tick();
    chk("rel1_cur", 32'(cur_a), 32'd3);
    tick();
    chk("rel2_cur", 32'(cur_a), 32'd4);
    tick();
    chk("rel3_vld", 32'(vld_a), 32'd1);
    chk("rel3_dout", 32'(dout_a), 32'h14);

    for (int i = 0; i < 12 && cur_a !== 3'd6; i++) tick();
    chk("reach_ch6", 32'(cur_a), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cur", 32'(cur_a), 32'h0);
    chk("async_rst_dout", 32'(dout_a), 32'h0);
    chk("async_rst_vld", 32'(vld_a), 32'h0);
    chk("async_rst_done", 32'(done_a), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("restart_cur", 32'(cur_a), 32'h0);
    chk("restart_dout", 32'(dout_a), 32'h10);
    chk("restart_vld", 32'(vld_a), 32'h1);
    tick(); tick(); tick();
    chk("restart_e4_cur", 32'(cur_a), 32'h0);
    tick();
    chk("restart_e5_cur", 32'(cur_a), 32'h1);

    // Instance B: CH=6 rejects out-of-range requests, DWELL=1 steps every cycle.
    sel_in_b = 3'd5; sel_load_b = 1'b1; tick();
    chk("b_load5_cur", 32'(cur_b), 32'd5);
    sel_in_b = 3'd7; tick();
    chk("b_load7_cur", 32'(cur_b), 32'd5);
    chk("b_load7_dout", 32'(dout_b), 32'h25);
    chk("b_load7_vld", 32'(vld_b), 32'd1);
    sel_in_b = 3'd6; tick();
    chk("b_load6_cur", 32'(cur_b), 32'd5);
    chk("b_load6_vld", 32'(vld_b), 32'd0);
    sel_load_b = 1'b0; mode_b = 1'b1; tick();
    chk("b_entry_cur", 32'(cur_b), 32'd5);
    for (int j = 1; j <= 12; j++) begin
      tick();
      ecur = (5 + j) % 6;
      chk($sformatf("b_scan%0d_cur", j), 32'(cur_b), 32'(ecur));
      chk($sformatf("b_scan%0d_done", j), 32'(done_b), 32'(ecur == 0));
      chk($sformatf("b_scan%0d_vld", j), 32'(vld_b), 32'(j >= 2));
      chk($sformatf("b_scan%0d_dout", j), 32'(dout_b), 32'(8'h20 + (4 + j) % 6));
    end

`ifdef CHAN_SCAN_PARITY_EN
    mode_a = 1'b0; tick();
    din_a[2*DW +: DW] = 8'b0000_0111;
    sel_in_a = 3'd2; sel_load_a = 1'b1; tick();
    sel_load_a = 1'b0; tick();
    chk("par_dout07", 32'(dout_a), 32'h07);
    chk("par_07", 32'(par_a), 32'd1);
    din_a[2*DW +: DW] = 8'h03; tick();
    chk("par_03", 32'(par_a), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
